// File: rtl/display_arbiter_if.sv
//------------------------------------------------------------------------------
// display_arbiter_if : requester-side bundle and display pins of the arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface display_arbiter_if;
  logic        encendido;
  logic [2:0]  req;
  logic [27:0] client0_digits;
  logic [27:0] client1_digits;
  logic [27:0] client2_digits;
  logic [2:0]  grant;
  logic        busy;
  logic [6:0]  display_controlador;
  logic [3:0]  enable_display;

  modport master (
    output encendido,
    output req,
    output client0_digits,
    output client1_digits,
    output client2_digits,
    input  grant,
    input  busy,
    input  display_controlador,
    input  enable_display
  );

  modport slave (
    input  encendido,
    input  req,
    input  client0_digits,
    input  client1_digits,
    input  client2_digits,
    output grant,
    output busy,
    output display_controlador,
    output enable_display
  );
endinterface

`default_nettype wire

// File: rtl/display_arbiter.sv
//------------------------------------------------------------------------------
// display_arbiter : fixed-priority owner of the 4-digit 7-seg display with hold,
// blanking and scan multiplexing. Option macro: DISPLAY_ARB_ALERT_PREEMPT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module display_arbiter #(
  parameter int SCAN_DIV     = 50000,
  parameter int HOLD_CYCLES  = 1000000,
  parameter int BLANK_CYCLES = 64
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  display_arbiter_if.slave  bus
);

  localparam int c_SCAN_W  = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;
  localparam int c_HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int c_BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LOAD  = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(BLANK_CYCLES - 1);

  localparam logic [6:0] c_SEG_OFF = 7'h7F;
  localparam logic [3:0] c_EN_OFF  = 4'hF;

  generate
    if (SCAN_DIV < 1 || HOLD_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_param_check
      $error("display_arbiter: SCAN_DIV, HOLD_CYCLES and BLANK_CYCLES must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_grant;
  logic                   r_busy;
  logic [6:0]             r_seg;
  logic [3:0]             r_en;
  logic [1:0]             r_digit;
  logic [c_SCAN_W-1:0]    r_scan_cnt;
  logic [c_HOLD_W-1:0]    r_hold_cnt;
  logic [c_BLANK_W-1:0]   r_blank_cnt;

  logic [2:0]  w_pick;
  logic [2:0]  w_higher;
  logic        w_hold_done;
  logic        w_release;
  logic        w_preempt;
  logic        w_leave;
  logic [27:0] w_owner_digits;
  logic [6:0]  w_owner_seg;

  always_comb begin
    w_pick = 3'b000;
    if (bus.req[2])      w_pick = 3'b100;
    else if (bus.req[1]) w_pick = 3'b010;
    else if (bus.req[0]) w_pick = 3'b001;
  end

  // Mask of clients that outrank the current owner.
  assign w_higher    = bus.req & {r_grant[1] | r_grant[0], r_grant[0], 1'b0};
  assign w_hold_done = (r_hold_cnt == '0);
  assign w_release   = ~|(bus.req & r_grant);

`ifdef DISPLAY_ARB_ALERT_PREEMPT_EN
  assign w_preempt = ((|w_higher) & w_hold_done) | (bus.req[2] & ~r_grant[2]);
`else
  assign w_preempt = (|w_higher) & w_hold_done;
`endif

  assign w_leave = w_release | w_preempt;

  always_comb begin
    w_owner_digits = bus.client0_digits;
    if (r_grant[2])      w_owner_digits = bus.client2_digits;
    else if (r_grant[1]) w_owner_digits = bus.client1_digits;
  end

  always_comb begin
    w_owner_seg = w_owner_digits[6:0];
    case (r_digit)
      2'd0:    w_owner_seg = w_owner_digits[6:0];
      2'd1:    w_owner_seg = w_owner_digits[13:7];
      2'd2:    w_owner_seg = w_owner_digits[20:14];
      default: w_owner_seg = w_owner_digits[27:21];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= 3'b000;
      r_busy      <= 1'b0;
      r_seg       <= c_SEG_OFF;
      r_en        <= c_EN_OFF;
      r_digit     <= 2'd0;
      r_scan_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_blank_cnt <= '0;
    end else if (!bus.encendido) begin
      r_state     <= S_IDLE;
      r_grant     <= 3'b000;
      r_busy      <= 1'b0;
      r_seg       <= c_SEG_OFF;
      r_en        <= c_EN_OFF;
      r_digit     <= 2'd0;
      r_scan_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_blank_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_seg <= c_SEG_OFF;
          r_en  <= c_EN_OFF;
          if (|bus.req) begin
            r_state    <= S_GRANT;
            r_grant    <= w_pick;
            r_busy     <= 1'b1;
            r_hold_cnt <= c_HOLD_LOAD;
            r_digit    <= 2'd0;
            r_scan_cnt <= '0;
          end
        end

        S_GRANT: begin
          if (w_leave) begin
            r_state     <= S_SWITCH;
            r_grant     <= 3'b000;
            r_blank_cnt <= '0;
            r_seg       <= c_SEG_OFF;
            r_en        <= c_EN_OFF;
          end else begin
            // Pins lag the digit register by one cycle.
            r_en  <= ~(4'b0001 << r_digit);
            r_seg <= w_owner_seg;
            if (!w_hold_done) begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if (r_scan_cnt == c_SCAN_LAST) begin
              r_scan_cnt <= '0;
              r_digit    <= r_digit + 1'b1;
            end else begin
              r_scan_cnt <= r_scan_cnt + 1'b1;
            end
          end
        end

        S_SWITCH: begin
          r_seg <= c_SEG_OFF;
          r_en  <= c_EN_OFF;
          if (r_blank_cnt == c_BLANK_LAST) begin
            if (|bus.req) begin
              r_state    <= S_GRANT;
              r_grant    <= w_pick;
              r_hold_cnt <= c_HOLD_LOAD;
              r_digit    <= 2'd0;
              r_scan_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= 3'b000;
          r_busy  <= 1'b0;
          r_seg   <= c_SEG_OFF;
          r_en    <= c_EN_OFF;
        end
      endcase
    end
  end

  assign bus.grant               = r_grant;
  assign bus.busy                = r_busy;
  assign bus.display_controlador = r_seg;
  assign bus.enable_display      = r_en;

endmodule

`default_nettype wire

// File: tb/tb_display_arbiter.sv
//------------------------------------------------------------------------------
// tb_display_arbiter : directed vector table plus reset / hold / live-content
// sequences for display_arbiter (SCAN_DIV=4, HOLD_CYCLES=20, BLANK_CYCLES=2).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  display_arbiter_if bus_if ();

  display_arbiter #(
    .SCAN_DIV     (4),
    .HOLD_CYCLES  (20),
    .BLANK_CYCLES (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       enc;
    logic [2:0] req;
    int         cycles;
    logic [2:0] grant;
    logic       busy;
    logic [3:0] en;
    logic [6:0] seg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic enc, input logic [2:0] req, input int cycles,
                     input logic [2:0] grant, input logic busy,
                     input logic [3:0] en, input logic [6:0] seg);
    vec_t v;
    v.enc = enc; v.req = req; v.cycles = cycles;
    v.grant = grant; v.busy = busy; v.en = en; v.seg = seg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic b,
                         input logic [3:0] en, input logic [6:0] seg);
    chk({tag, ".grant"}, 32'(bus_if.grant), 32'(g));
    chk({tag, ".busy"},  32'(bus_if.busy),  32'(b));
    chk({tag, ".en"},    32'(bus_if.enable_display), 32'(en));
    chk({tag, ".seg"},   32'(bus_if.display_controlador), 32'(seg));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.encendido      = 1'b1;
    bus_if.req            = 3'b001;
    bus_if.client0_digits = {7'h13, 7'h12, 7'h11, 7'h10};
    bus_if.client1_digits = {7'h23, 7'h22, 7'h21, 7'h20};
    bus_if.client2_digits = {7'h33, 7'h32, 7'h31, 7'h30};

    // Scenario 1: first grant, scan sequence E,D,B,7 at 4 cycles per digit.
    add(1, 3'b001, 1,  3'b001, 1, 4'hF, 7'h7F);
    add(1, 3'b001, 1,  3'b001, 1, 4'hE, 7'h10);
    add(1, 3'b001, 3,  3'b001, 1, 4'hE, 7'h10);
    add(1, 3'b001, 1,  3'b001, 1, 4'hD, 7'h11);
    add(1, 3'b001, 4,  3'b001, 1, 4'hB, 7'h12);
    add(1, 3'b001, 4,  3'b001, 1, 4'h7, 7'h13);
    // Scenario 2: client 1 waits for hold, then a 2-cycle blank.
    add(1, 3'b011, 1,  3'b001, 1, 4'h7, 7'h13);
    add(1, 3'b011, 5,  3'b001, 1, 4'hE, 7'h10);
    add(1, 3'b011, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b010, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b010, 1, 4'hE, 7'h20);
    add(1, 3'b011, 1,  3'b010, 1, 4'hE, 7'h20);
    // Scenario 3: owner release switches immediately, no hold wait for client 0.
    add(1, 3'b001, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b001, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b001, 1,  3'b001, 1, 4'hF, 7'h7F);
    add(1, 3'b001, 1,  3'b001, 1, 4'hE, 7'h10);
    // Back to idle, then req=111 picks client 2; its release hands to client 1.
    add(1, 3'b000, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b000, 2,  3'b000, 0, 4'hF, 7'h7F);
    add(1, 3'b111, 1,  3'b100, 1, 4'hF, 7'h7F);
    add(1, 3'b111, 1,  3'b100, 1, 4'hE, 7'h30);
    add(1, 3'b011, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b010, 1, 4'hF, 7'h7F);
    add(1, 3'b011, 1,  3'b010, 1, 4'hE, 7'h20);
    // Scenario 5: power off forces idle with no blank phase.
    add(0, 3'b011, 1,  3'b000, 0, 4'hF, 7'h7F);
    add(0, 3'b011, 1,  3'b000, 0, 4'hF, 7'h7F);
    add(1, 3'b010, 1,  3'b010, 1, 4'hF, 7'h7F);
    add(1, 3'b010, 1,  3'b010, 1, 4'hE, 7'h20);
    // Scenario 6: alert request against a fresh client-0 grant.
    add(1, 3'b001, 3,  3'b001, 1, 4'hF, 7'h7F);
    add(1, 3'b001, 3,  3'b001, 1, 4'hE, 7'h10);
`ifdef DISPLAY_ARB_ALERT_PREEMPT_EN
    add(1, 3'b101, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b100, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b100, 1, 4'hE, 7'h30);
`else
    add(1, 3'b101, 1,  3'b001, 1, 4'hE, 7'h10);
    add(1, 3'b101, 15, 3'b001, 1, 4'hE, 7'h10);
    add(1, 3'b101, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b000, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b100, 1, 4'hF, 7'h7F);
    add(1, 3'b101, 1,  3'b100, 1, 4'hE, 7'h30);
`endif

    // Held in reset across clock edges with a request pending.
    #23;
    chk_all("reset", 3'b000, 1'b0, 4'hF, 7'h7F);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      bus_if.encendido = tbl[i].enc;
      bus_if.req       = tbl[i].req;
      tick(tbl[i].cycles);
      chk_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].en, tbl[i].seg);
    end

    // Asynchronous reset while a client owns the display: no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'b000, 1'b0, 4'hF, 7'h7F);
    #2;
    rst_n = 1'b1;

    // Lower-priority request never preempts, even long after hold expiry.
    bus_if.encendido = 1'b1;
    bus_if.req       = 3'b010;
    tick(1);
    chk("low_prio.first", 32'(bus_if.grant), 32'(3'b010));
    bus_if.req = 3'b011;
    tick(26);
    chk_all("low_prio.hold", 3'b010, 1'b1, 4'hB, 7'h22);

    // Owner content is sampled live.
    bus_if.client1_digits[20:14] = 7'h5A;
    tick(1);
    chk("live.seg", 32'(bus_if.display_controlador), 32'(7'h5A));
    chk("live.en",  32'(bus_if.enable_display), 32'(4'hB));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
